// File: rtl/Utilities.sv
// Shared decode-stage types and the GPIO address map used by the load/store path.
package Utilities;

  typedef enum logic [2:0] {
    UOP_NOP    = 3'd0,
    UOP_ALU    = 3'd1,
    UOP_LDR    = 3'd2,
    UOP_STR    = 3'd3,
    UOP_BRANCH = 3'd4,
    UOP_JUMP   = 3'd5
  } Uop;

  localparam logic [31:0] GPIO_DATA_ADDR     = 32'd32;
  localparam logic [31:0] GPIO_EDGE_CLR_ADDR = 32'd33;
  localparam int          GPIO_WIDTH         = 16;

  function automatic logic is_store_to(input Uop u, input logic [31:0] a,
                                       input logic [31:0] target);
    return (u == UOP_STR) && (a == target);
  endfunction

endpackage

// File: rtl/gpio_port_if.sv
// Load/store bus between the execute stage (master) and the GPIO port (slave).
interface gpio_port_if;
  import Utilities::*;

  // uop/addr/wdata are valid every cycle; there is no ready because the port
  // accepts every store and answers every load in the same cycle.
  Uop          uop;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] gpio_state;
  logic        edge_irq;

  modport master (output uop, addr, wdata, input gpio_state, edge_irq);
  modport slave  (input uop, addr, wdata, output gpio_state, edge_irq);

endinterface

// File: rtl/gpio_debounce.sv
// One input bit: 2-flop synchronizer, then (when GPIO_DEBOUNCE_EN is defined)
// a saturating run counter that gates changes of the stable bit.
module gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_in,
  output logic stable_o,
  output logic rise_o
);

  if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > 255)) begin : g_bad_cycles
    $error("gpio_debounce: DEBOUNCE_CYCLES must be in 1..255");
  end

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = pin_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       stable_q, stable_d;

  // The counter stops at LAST_CNT: reaching it with the bit still different
  // commits the new level and clears, so it never wraps.
  always_comb begin
    cnt_d    = 8'd0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == LAST_CNT) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 8'd0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = stable_d & ~stable_q;
`else
  // Without debounce the second synchronizer flop is the stable bit.
  assign stable_o = sync2_q;
  assign rise_o   = sync2_d & ~sync2_q;
`endif

endmodule

// File: rtl/gpio_port.sv
// 16-bit GPIO port: output data/enable registers, synchronized (optionally
// debounced via GPIO_DEBOUNCE_EN) inputs, rising-edge flags with W1C clear.
module gpio_port
  import Utilities::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gpio_port_if.slave            bus,
  input  logic [GPIO_WIDTH-1:0] pins_in,
  output logic [GPIO_WIDTH-1:0] pins_out,
  output logic [GPIO_WIDTH-1:0] pins_oe
);

  logic [GPIO_WIDTH-1:0] out_q,  out_d;
  logic [GPIO_WIDTH-1:0] oe_q,   oe_d;
  logic [GPIO_WIDTH-1:0] edge_q, edge_d;
  logic [GPIO_WIDTH-1:0] stable;
  logic [GPIO_WIDTH-1:0] rise;

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_bit
    gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .pin_in   (pins_in[i]),
      .stable_o (stable[i]),
      .rise_o   (rise[i])
    );
  end

  always_comb begin
    out_d  = out_q;
    oe_d   = oe_q;
    edge_d = edge_q;
    if (is_store_to(bus.uop, bus.addr, GPIO_DATA_ADDR)) begin
      out_d = bus.wdata[15:0];
      oe_d  = bus.wdata[31:16];
    end
    if (is_store_to(bus.uop, bus.addr, GPIO_EDGE_CLR_ADDR)) begin
      edge_d = edge_q & ~bus.wdata[31:16];
    end
    // A rise landing in the clear cycle must not be lost, so set is applied last.
    edge_d = edge_d | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      oe_q   <= '0;
      edge_q <= '0;
    end else begin
      out_q  <= out_d;
      oe_q   <= oe_d;
      edge_q <= edge_d;
    end
  end

  assign pins_out       = out_q;
  assign pins_oe        = oe_q;
  assign bus.gpio_state = {edge_q, stable};
  assign bus.edge_irq   = |edge_q;

endmodule

// File: tb/tb_gpio_port.sv
// Directed + randomized bench for gpio_port against a pin-history reference model.
module tb_gpio_port;
  import Utilities::*;

  localparam int DC = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 2 + DC;
`else
  localparam int LAT = 2;
`endif
  localparam int HIST = DC + 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pins_in;
  logic [15:0] pins_out;
  logic [15:0] pins_oe;

  gpio_port_if bus();

  gpio_port #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .pins_in  (pins_in),
    .pins_out (pins_out),
    .pins_oe  (pins_oe)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_out, m_oe, m_stable, m_flags;
  logic [15:0] pin_hist[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic model_reset();
    m_out = '0; m_oe = '0; m_stable = '0; m_flags = '0;
    pin_hist.delete();
    for (int i = 0; i < HIST; i++) pin_hist.push_front(16'h0000);
  endtask

  // pin_hist[k] is the pin level sampled k edges ago (0 = this edge).
  task automatic model_edge();
    logic [15:0] new_stable;
    logic [15:0] rise;
    logic        all_diff;
    pin_hist.push_front(pins_in);
    if (pin_hist.size() > HIST) void'(pin_hist.pop_back());
`ifdef GPIO_DEBOUNCE_EN
    new_stable = m_stable;
    for (int b = 0; b < 16; b++) begin
      all_diff = 1'b1;
      for (int i = 0; i < DC; i++)
        if (pin_hist[2+i][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) new_stable[b] = ~m_stable[b];
    end
`else
    new_stable = pin_hist[1];
`endif
    rise = new_stable & ~m_stable;
    if (bus.uop == UOP_STR && bus.addr == 32'd32) {m_oe, m_out} = bus.wdata;
    if (bus.uop == UOP_STR && bus.addr == 32'd33) m_flags = m_flags & ~bus.wdata[31:16];
    m_flags  = m_flags | rise;
    m_stable = new_stable;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".pins_out"},   {16'h0, pins_out},   {16'h0, m_out});
    cmp({tag, ".pins_oe"},    {16'h0, pins_oe},    {16'h0, m_oe});
    cmp({tag, ".gpio_state"}, bus.gpio_state,      {m_flags, m_stable});
    cmp({tag, ".edge_irq"},   {31'h0, bus.edge_irq}, {31'h0, |m_flags});
  endtask

  task automatic set_bus(input Uop u, input logic [31:0] a, input logic [31:0] w);
    bus.uop = u; bus.addr = a; bus.wdata = w;
  endtask

  // Inputs change at negedge; outputs are checked at the following negedge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all("cyc");
  endtask

  initial begin
    rst_n   = 1'b0;
    pins_in = 16'h0000;
    set_bus(UOP_NOP, 32'd0, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Output register write, then non-store uops and a foreign address
    set_bus(UOP_STR, 32'd32, 32'h00FF_00A5);
    tick();
    cmp("str32.out", {16'h0, pins_out}, 32'h0000_00A5);
    cmp("str32.oe",  {16'h0, pins_oe},  32'h0000_00FF);
    set_bus(UOP_LDR, 32'd32, 32'hFFFF_FFFF); tick();
    set_bus(UOP_ALU, 32'd32, 32'h1234_5678); tick();
    set_bus(UOP_STR, 32'd34, 32'hFFFF_FFFF); tick();
    set_bus(UOP_NOP, 32'd0, 32'd0);
    cmp("hold.out", {16'h0, pins_out}, 32'h0000_00A5);
    cmp("hold.oe",  {16'h0, pins_oe},  32'h0000_00FF);

    // Rising edge on bit 3: visible after exactly LAT edges
    pins_in[3] = 1'b1;
    repeat (LAT - 1) tick();
    cmp("lat.early", {31'h0, bus.gpio_state[3]}, 32'd0);
    tick();
    cmp("lat.bit3",  {31'h0, bus.gpio_state[3]},  32'd1);
    cmp("lat.flag19", {31'h0, bus.gpio_state[19]}, 32'd1);
    cmp("lat.irq",   {31'h0, bus.edge_irq},       32'd1);

`ifdef GPIO_DEBOUNCE_EN
    // Two-cycle glitch must be rejected
    pins_in[0] = 1'b1; tick(); tick();
    pins_in[0] = 1'b0;
    repeat (LAT + 2) tick();
    cmp("glitch.bit0",   {31'h0, bus.gpio_state[0]},  32'd0);
    cmp("glitch.flag16", {31'h0, bus.gpio_state[16]}, 32'd0);
`endif

    // W1C of flag 19 leaves flag 16
    pins_in[0] = 1'b1;
    repeat (LAT + 1) tick();
    cmp("w1c.pre16", {31'h0, bus.gpio_state[16]}, 32'd1);
    set_bus(UOP_STR, 32'd33, 32'h0008_0000); tick();
    set_bus(UOP_NOP, 32'd0, 32'd0);
    cmp("w1c.flag19", {31'h0, bus.gpio_state[19]}, 32'd0);
    cmp("w1c.flag16", {31'h0, bus.gpio_state[16]}, 32'd1);
    cmp("w1c.irq",    {31'h0, bus.edge_irq},       32'd1);

    // New rise on bit 3 landing in the clear cycle: set wins
    pins_in[3] = 1'b0;
    repeat (LAT + 1) tick();
    pins_in[3] = 1'b1;
    repeat (LAT - 1) tick();
    set_bus(UOP_STR, 32'd33, 32'h0008_0000); tick();
    set_bus(UOP_NOP, 32'd0, 32'd0);
    cmp("setwins.flag19", {31'h0, bus.gpio_state[19]}, 32'd1);

    // Asynchronous reset mid-debounce with all outputs driven
    set_bus(UOP_STR, 32'd32, 32'hFFFF_FFFF); tick();
    set_bus(UOP_NOP, 32'd0, 32'd0);
    pins_in[5] = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    cmp("async_rst.out",   {16'h0, pins_out},     32'd0);
    cmp("async_rst.state", bus.gpio_state,        32'd0);
    cmp("async_rst.irq",   {31'h0, bus.edge_irq}, 32'd0);
    tick();
    rst_n = 1'b1;
    set_bus(UOP_STR, 32'd32, 32'h0000_1234);
    tick();
    set_bus(UOP_NOP, 32'd0, 32'd0);
    cmp("post_rst.str", {16'h0, pins_out}, 32'h0000_1234);
    repeat (LAT - 2) tick();
    cmp("restart.bit5.early", {31'h0, bus.gpio_state[5]}, 32'd0);
    tick();
    cmp("restart.bit5", {31'h0, bus.gpio_state[5]}, 32'd1);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0:       a = 32'd32;
        1:       a = 32'd33;
        2:       a = 32'd34;
        default: a = $urandom;
      endcase
      set_bus(Uop'($urandom_range(0, 5)), a, $urandom);
      if ($urandom_range(0, 5) == 0) pins_in[$urandom_range(0, 15)] ^= 1'b1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_port.md
GPIO_PORT -- requirements
Module: gpio_port

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive differing synchronized samples required before a debounced input bit changes; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 uop  input  Uop  current micro-op from the decode stage.
REQ-005 addr  input  32  data address from the ALU.
REQ-006 wdata  input  32  store data from the register file.
REQ-007 pins_in  input  16  raw, asynchronous external pin levels.
REQ-008 pins_out  output  16  registered output data to pads.
REQ-009 pins_oe  output  16  registered per-pin output enable; 1 = drive.
REQ-010 gpio_state  output  32  registered read value consumed by the register return mux on LDR from address 32.
REQ-011 edge_irq  output  1  OR of all edge-capture flags.

Function
REQ-012 Address map: 32 = GPIO_DATA, 33 = GPIO_EDGE_CLR; other addresses ignored.
REQ-013 STR with addr 32 captures wdata[15:0] into pins_out and wdata[31:16] into pins_oe on that clock edge; outputs change one edge after the STR cycle.
REQ-014 STR with addr 33 clears each edge flag whose wdata[n+16] bit is 1 (write-1-to-clear); wdata[15:0] ignored.
REQ-015 Any uop other than STR, or STR to any other address, changes no register.
REQ-016 pins_in passes through a 2-flop synchronizer per bit before any other use.
REQ-017 Debounce per bit: counter clears while synced bit equals stable bit; increments while different; stable bit takes synced value and counter clears when count reaches DEBOUNCE_CYCLES-1 with the bit still different.
REQ-018 Counter width 8 bits; counter never wraps.
REQ-019 Edge flag n sets on a 0->1 transition of stable bit n.
REQ-020 Set and W1C clear of the same flag in the same cycle: set wins.
REQ-021 gpio_state[15:0] = stable inputs, gpio_state[31:16] = edge flags, both registered; LDR reads are combinational from these registers, zero wait states.
REQ-022 Pin-to-gpio_state latency: 2 cycles synchronizer + DEBOUNCE_CYCLES cycles debounce.
REQ-023 edge_irq is combinational OR of gpio_state[31:16].

Reset
REQ-024 rst_n low clears pins_out, pins_oe, synchronizer flops, stable bits, counters, edge flags, gpio_state and edge_irq to 0 immediately, independent of clk.
REQ-025 A STR coincident with the first edge after deassertion is honoured; a debounce in progress at reset assertion is discarded.

Configuration
REQ-026 Macro GPIO_DEBOUNCE_EN: when defined, debounce per REQ-017; when undefined, stable bits equal the synchronizer output, no counters are built, DEBOUNCE_CYCLES ignored, latency 2 cycles.

Structure
REQ-027 Constants GPIO_DATA_ADDR (32'd32) and GPIO_EDGE_CLR_ADDR (32'd33) go in package Utilities alongside Uop.
REQ-028 One sub-module gpio_debounce (1-bit synchronizer + counter + stable bit), instantiated 16 times via generate.

Verification
REQ-029 Reset, then STR addr 32 wdata 0x00FF_00A5 -> next edge pins_out=0x00A5, pins_oe=0x00FF; LDR/other uops leave them unchanged.
REQ-030 With GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: pins_in[3] 0->1 held -> gpio_state[3]=1 exactly 6 cycles later, gpio_state[19]=1, edge_irq=1.
REQ-031 Glitch: pins_in[0] high for 2 cycles then low -> gpio_state[0] and flag 16 remain 0.
REQ-032 Flags 16 and 19 set; STR addr 33 wdata 0x0008_0000 -> flag 19 clears, flag 16 stays, edge_irq stays 1; new rising edge on bit 3 in the clear cycle -> flag 19 stays 1.
REQ-033 STR addr 34 wdata 0xFFFF_FFFF -> no register changes.
REQ-034 rst_n pulsed low mid-debounce and with pins_out=0xFFFF -> all outputs 0 before the next clk edge; debounce restarts from zero count.
